// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a register-file memory, with WAIT programmable wait states.
// Define APB_SLAVE_PSLVERR_EN to answer out-of-range addresses with pslverr instead of aliasing them.
module apb_slave_mem #(
  parameter int AW    = 9,
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr
);
  localparam int         IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state, nxt_state;
  logic [3:0]    cnt, nxt_cnt;
  logic [AW-1:0] addr_lat;
  logic [DW-1:0] wdata_lat;
  logic          write_lat;
  logic [DW-1:0] mem [DEPTH];

  logic          latch, mem_we, rd_load, rd_err;
  logic          in_err, lat_err;
  logic [AW-1:0] rd_addr;

`ifdef APB_SLAVE_PSLVERR_EN
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  assign in_err  = ({1'b0, paddr} >= DEPTH_W);
  assign lat_err = ({1'b0, addr_lat} >= DEPTH_W);
  assign pslverr = pready & lat_err;
`else
  logic unused_addr;
  assign in_err      = 1'b0;
  assign lat_err     = 1'b0;
  assign unused_addr = ^addr_lat;
  assign pslverr     = 1'b0;
`endif

  assign pready = (state == ACCESS) && (cnt == 4'd0);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  // Zero-wait reads must fetch at the setup edge, so they look at the live address.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    latch     = 1'b0;
    mem_we    = 1'b0;
    rd_load   = 1'b0;
    rd_addr   = addr_lat;
    rd_err    = lat_err;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          nxt_state = ACCESS;
          nxt_cnt   = WAIT_C;
          latch     = 1'b1;
          if ((WAIT_C == 4'd0) && !pwrite) begin
            rd_load = 1'b1;
            rd_addr = paddr;
            rd_err  = in_err;
          end
        end
      end
      ACCESS: begin
        if (!psel) begin
          nxt_state = IDLE;
        end else if (penable) begin
          if (cnt != 4'd0) begin
            nxt_cnt = cnt - 4'd1;
            rd_load = (cnt == 4'd1) && !write_lat;
          end else begin
            nxt_state = IDLE;
            mem_we    = write_lat && !lat_err;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (latch) begin
      addr_lat  <= paddr;
      wdata_lat <= pwdata;
      write_lat <= pwrite;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata <= '0;
    end else if (rd_load) begin
      prdata <= rd_err ? '0 : mem[rd_addr[IW-1:0]];
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[addr_lat[IW-1:0]] <= wdata_lat;
    end
  end
endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: a WAIT=2 and a WAIT=0 instance checked against a byte-array memory model.
module tb_apb_slave_mem;
  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
`ifdef APB_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          pclk = 1'b0;
  logic          presetn;
  logic          psel    [2];
  logic          penable [2];
  logic          pwrite  [2];
  logic [AW-1:0] paddr   [2];
  logic [DW-1:0] pwdata  [2];
  logic [DW-1:0] prdata  [2];
  logic          pready  [2];
  logic          pslverr [2];

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] ref_mem [2][DEPTH];
  logic [DW-1:0] ref_rd  [2];

  always #5 pclk = ~pclk;

  apb_slave_mem #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT(2)) dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_slave_mem #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT(0)) dut1 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      ref_rd[u] = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[u][i] = '0;
    end
  endtask

  task automatic idle_bus();
    for (int u = 0; u < 2; u++) begin
      psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0;
      paddr[u] = '0;  pwdata[u] = '0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk({tag, "_pready"},  32'(pready[u]),  32'(0));
      chk({tag, "_pslverr"}, 32'(pslverr[u]), 32'(0));
      chk({tag, "_prdata"},  32'(prdata[u]),  32'(0));
    end
  endtask

  // Complete setup+access transfer on unit u; entered and left #1 after a rising edge.
  task automatic xfer(input int u, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    int w;
    int idx;
    bit err;
    w   = (u == 0) ? 2 : 0;
    idx = int'(a) % DEPTH;
    err = ERR_EN && (int'(a) >= DEPTH);
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr; paddr[u] = a; pwdata[u] = d;
    chk("setup_pready", 32'(pready[u]), 32'(0));
    @(posedge pclk); #1;
    penable[u] = 1'b1;
    pwdata[u]  = ~d;
    pwrite[u]  = ~wr;
    paddr[u]   = AW'($urandom);
    n = 1;
    while (pready[u] !== 1'b1 && n <= 20) begin
      @(posedge pclk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(w + 1));
    if (wr) begin
      if (!err) ref_mem[u][idx] = d;
    end else begin
      ref_rd[u] = err ? '0 : ref_mem[u][idx];
    end
    chk("pslverr", 32'(pslverr[u]), 32'(err));
    chk("prdata", 32'(prdata[u]), 32'(ref_rd[u]));
    @(posedge pclk); #1;
    psel[u] = 1'b0; penable[u] = 1'b0;
    chk("pready_one_cycle", 32'(pready[u]), 32'(0));
    chk("prdata_hold", 32'(prdata[u]), 32'(ref_rd[u]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    model_reset();
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk_reset_outputs("rst");
    presetn = 1'b1;
    @(posedge pclk); #1;
    chk_reset_outputs("post_rst");
    xfer(0, 1'b0, 9'h005, 8'h00);
    xfer(1, 1'b0, 9'h005, 8'h00);

    xfer(0, 1'b1, 9'h012, 8'hA5);
    xfer(0, 1'b0, 9'h012, 8'h00);

    // Reset pulsed mid-cycle during the wait states of a write
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 9'h030; pwdata[0] = 8'h5A;
    @(posedge pclk); #1;
    penable[0] = 1'b1;
    @(posedge pclk); #2;
    presetn = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    idle_bus();
    @(posedge pclk); #2;
    presetn = 1'b1;
    model_reset();
    @(posedge pclk); #1;
    xfer(0, 1'b0, 9'h030, 8'h00);

    xfer(1, 1'b1, 9'h000, 8'h11);
    xfer(1, 1'b1, 9'h001, 8'h22);
    xfer(1, 1'b1, 9'h002, 8'h33);
    xfer(1, 1'b0, 9'h000, 8'h00);
    xfer(1, 1'b0, 9'h001, 8'h00);
    xfer(1, 1'b0, 9'h002, 8'h00);

    xfer(0, 1'b1, 9'h007, 8'hC3);
    xfer(0, 1'b0, 9'h007, 8'h00);
    // Abort: psel dropped in the second wait cycle
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 9'h020; pwdata[0] = 8'hFF;
    @(posedge pclk); #1;
    penable[0] = 1'b1;
    chk("abort_wait1_pready", 32'(pready[0]), 32'(0));
    @(posedge pclk); #1;
    chk("abort_wait2_pready", 32'(pready[0]), 32'(0));
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge pclk); #1;
    chk("abort_pready", 32'(pready[0]), 32'(0));
    chk("abort_prdata", 32'(prdata[0]), 32'(ref_rd[0]));
    xfer(0, 1'b0, 9'h020, 8'h00);

    // Access phase without a setup phase is ignored
    for (int u = 0; u < 2; u++) begin
      psel[u] = 1'b1; penable[u] = 1'b1; pwrite[u] = 1'b1; paddr[u] = 9'h040; pwdata[u] = 8'h99;
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk); #1;
      chk("nosetup_pready0", 32'(pready[0]), 32'(0));
      chk("nosetup_pready1", 32'(pready[1]), 32'(0));
    end
    idle_bus();
    @(posedge pclk); #1;
    xfer(0, 1'b0, 9'h040, 8'h00);
    xfer(1, 1'b0, 9'h040, 8'h00);

    // Out-of-range address: error response or alias, depending on build
    for (int u = 0; u < 2; u++) begin
      xfer(u, 1'b1, 9'h105, 8'h77);
      xfer(u, 1'b0, 9'h105, 8'h00);
      xfer(u, 1'b0, 9'h005, 8'h00);
    end

    for (int k = 0; k < 80; k++) begin
      int u;
      bit wr;
      logic [AW-1:0] a;
      u  = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      a  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      xfer(u, wr, a, DW'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge pclk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer (slave) with an internal register-file memory and programmable wait-state insertion. It sits on the bus side of the team's APB bridge as one of the two slaves the bridge selects. It answers the bridge's setup/access phases with PREADY, PRDATA and, optionally, PSLVERR. It gives the bridge's transfer, read-data and wait-state paths a cycle-accurate partner.

## Interface
- AW, default 9: paddr width.
- DW, default 8: data width.
- DEPTH, default 256: memory words; must be a power of two, at most 2^AW.
- WAIT, default 2: wait cycles inserted per transfer; legal range 0..15.
- pclk  in  1  bus clock; all state changes on its rising edge.
- presetn  in  1  reset; asynchronous and active-low.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  AW  byte/word address.
- pwdata  in  DW  write data.
- prdata  out  DW  read data.
- pready  out  1  transfer completion.
- pslverr  out  1  error response; tied 0 unless the macro in Configuration is defined.

## Operation
- FSM states:
  - IDLE: pready = 0.
  - ACCESS: pready = (cnt == 0).
  - cnt is a 4-bit wait counter.
- IDLE -> ACCESS:
  - Occurs on an edge with psel=1 and penable=0 (setup phase).
  - At that edge, latch paddr, pwrite and pwdata into internal registers and load cnt = WAIT.
- ACCESS, edge with psel=1, penable=1, cnt>0: decrement cnt and stay in ACCESS.
- ACCESS, edge with psel=1, penable=1, cnt==0 (completion edge):
  - Write: mem[addr] <= latched wdata.
  - Go to IDLE.
- ACCESS, edge with psel=0: transfer aborted. Go to IDLE, no memory write, prdata unchanged.
- IDLE, edge with psel=1 and penable=1 (access without setup): ignored, stay IDLE, no response.
- Reads:
  - prdata is registered. It is loaded with mem[addr] on the edge where cnt becomes 0, or at the setup edge when WAIT=0.
  - prdata is therefore valid throughout the pready=1 cycle.
  - prdata holds its value after completion until the next read completes, so the bus never sees X after reset.
  - Writes never modify prdata.
- Memory index = paddr[$clog2(DEPTH)-1:0].
- All outputs are decoded from flops; there is no combinational input-to-output path.

## Timing
- Reset values: state=IDLE, cnt=0, pready=0, pslverr=0, prdata=0, all memory words=0.
- Reset asserted mid-transfer: immediate return to IDLE, pending write dropped, outputs forced to reset values.
- Latency:
  - Setup edge to pready=1 takes WAIT+1 cycles.
  - A full transfer takes WAIT+2 cycles including setup.
  - With WAIT=0 a transfer takes 2 cycles (zero-wait APB).
- Back-to-back transfers: the completion edge returns the FSM to IDLE. A new setup phase in the following cycle is accepted at the next edge, so there are no dead cycles beyond APB's mandatory setup.
- pready is high for exactly one cycle per completed transfer.
- Inputs changing during ACCESS are ignored; only the values latched at the setup edge are used.

## Configuration
- APB_SLAVE_PSLVERR_EN defined:
  - Latched paddr >= DEPTH flags an error. pslverr=1 in the pready cycle, which is the same cycle as pready.
  - Errored write: memory is not modified.
  - Errored read: prdata is loaded with 0.
  - pslverr=0 in all other cycles.
- APB_SLAVE_PSLVERR_EN undefined: pslverr is constant 0 and out-of-range addresses alias modulo DEPTH.

## Test plan
- Reset check: presetn low for 3 cycles, then high.
  - Required: pready=0, pslverr=0, prdata=0.
  - Required: a read of addr 0x05 returns 0x00.
- Write then read with WAIT=2: write 0xA5 to addr 0x12, then read 0x12.
  - Required: pready rises 3 cycles after each setup edge and stays high 1 cycle.
  - Required: prdata=0xA5 in the read's pready cycle and held afterwards.
- Zero-wait back-to-back with WAIT=0: writes of 0x11, 0x22 and 0x33 to addr 0x00, 0x01 and 0x02 on consecutive setup/access pairs, then three reads.
  - Required: each transfer takes 2 cycles.
  - Required: the reads return 0x11, 0x22, 0x33.
- Abort and protocol errors:
  - psel dropped in the 2nd wait cycle of a write of 0xFF to 0x20 -> a read of 0x20 returns the previous value 0x00.
  - psel=1 and penable=1 with no setup -> pready stays 0.
- Reset mid-transfer: presetn pulsed low during the wait cycles of a write of 0x5A to 0x30.
  - Required: outputs go to reset values asynchronously.
  - Required: a subsequent read of 0x30 returns 0x00.
- Error response with the macro defined: write 0x77 to 0x105, then read 0x105 and read 0x005.
  - Required: pslverr=1 with pready on both accesses to 0x105.
  - Required: the read of 0x105 returns 0x00.
  - Required: the read of 0x005 returns 0x00 with pslverr=0.
  - With the macro undefined, the same write makes 0x005 read back 0x77.
